// File: rtl/bsg_dram_ctrl_app_mem.sv
// bsg_dram_ctrl_app_mem
// Stand-in responder for the DRAM-controller app interface. Accepts burst commands and write
// data through two independent queues, holds a word-array memory, and returns read bursts in
// command order with registered outputs.
//
// Ports
//   clk_i, reset_i             clock, synchronous active-high reset
//   app_en_i / app_rdy_o       command handshake (accept = en & rdy)
//   app_cmd_i, app_addr_i      command (WR=000, RD=001) and burst-start byte address
//   app_wdf_wren_i / _rdy_o    write-data handshake
//   app_wdf_data_i/_mask_i     write beat and byte mask (1 = byte not written)
//   app_wdf_end_i              last beat of a write burst
//   app_rd_data_valid_o        read beat valid (no backpressure)
//   app_rd_data_o, _end_o      read beat and last-beat marker
//   error_o                    sticky protocol-error flag
module bsg_dram_ctrl_app_mem #(
  parameter int unsigned data_width_p   = 64,
  parameter int unsigned addr_width_p   = 28,
  parameter int unsigned burst_len_p    = 4,
  parameter int unsigned mem_els_p      = 1024,
  parameter int unsigned cmd_fifo_els_p = 4,
  parameter int unsigned wdf_fifo_els_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      app_en_i,
  output logic                      app_rdy_o,
  input  logic [2:0]                app_cmd_i,
  input  logic [addr_width_p-1:0]   app_addr_i,
  input  logic                      app_wdf_wren_i,
  output logic                      app_wdf_rdy_o,
  input  logic [data_width_p-1:0]   app_wdf_data_i,
  input  logic [data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                      app_wdf_end_i,
  output logic                      app_rd_data_valid_o,
  output logic [data_width_p-1:0]   app_rd_data_o,
  output logic                      app_rd_data_end_o,
  output logic                      error_o
);

  localparam int unsigned BytesPerBeat = data_width_p / 8;
  localparam int unsigned ByteOffW     = (BytesPerBeat > 1) ? $clog2(BytesPerBeat) : 0;
  localparam int unsigned IdxW         = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int unsigned BeatW        = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int unsigned CmdPtrW      = (cmd_fifo_els_p > 1) ? $clog2(cmd_fifo_els_p) : 1;
  localparam int unsigned CmdCntW      = $clog2(cmd_fifo_els_p + 1);
  localparam int unsigned WdfPtrW      = (wdf_fifo_els_p > 1) ? $clog2(wdf_fifo_els_p) : 1;
  localparam int unsigned WdfCntW      = $clog2(wdf_fifo_els_p + 1);

  localparam logic [2:0]       CmdWr    = 3'b000;
  localparam logic [2:0]       CmdRd    = 3'b001;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(burst_len_p - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  // ---------------------------------------------------------------------------------------------
  // Command queue: stores opcode and word index only; upper address bits are dropped here.
  // ---------------------------------------------------------------------------------------------
  logic [2:0]         r_cmd_op  [cmd_fifo_els_p];
  logic [IdxW-1:0]    r_cmd_idx [cmd_fifo_els_p];
  logic [CmdPtrW-1:0] r_cmd_wptr, r_cmd_rptr;
  logic [CmdCntW-1:0] r_cmd_cnt;
  logic               w_cmd_push, w_cmd_pop, w_cmd_empty;
  logic               w_unused_addr;

  assign app_rdy_o     = (r_cmd_cnt != CmdCntW'(cmd_fifo_els_p));
  assign w_cmd_push    = app_en_i & app_rdy_o;
  assign w_cmd_empty   = (r_cmd_cnt == '0);
  assign w_unused_addr = ^app_addr_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cmd_wptr <= '0;
      r_cmd_rptr <= '0;
      r_cmd_cnt  <= '0;
    end else begin
      if (w_cmd_push) begin
        r_cmd_wptr <= (r_cmd_wptr == CmdPtrW'(cmd_fifo_els_p - 1)) ? '0
                                                                    : r_cmd_wptr + CmdPtrW'(1);
      end
      if (w_cmd_pop) begin
        r_cmd_rptr <= (r_cmd_rptr == CmdPtrW'(cmd_fifo_els_p - 1)) ? '0
                                                                    : r_cmd_rptr + CmdPtrW'(1);
      end
      if (w_cmd_push && !w_cmd_pop) begin
        r_cmd_cnt <= r_cmd_cnt + CmdCntW'(1);
      end else if (!w_cmd_push && w_cmd_pop) begin
        r_cmd_cnt <= r_cmd_cnt - CmdCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_cmd_push) begin
      r_cmd_op[r_cmd_wptr]  <= app_cmd_i;
      r_cmd_idx[r_cmd_wptr] <= app_addr_i[ByteOffW +: IdxW];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Write-data queue
  // ---------------------------------------------------------------------------------------------
  logic [data_width_p-1:0] r_wdf_data [wdf_fifo_els_p];
  logic [BytesPerBeat-1:0] r_wdf_mask [wdf_fifo_els_p];
  logic [WdfPtrW-1:0]      r_wdf_wptr, r_wdf_rptr;
  logic [WdfCntW-1:0]      r_wdf_cnt;
  logic                    w_wdf_push, w_wdf_pop, w_wdf_empty;
  logic [data_width_p-1:0] w_wdf_head_data;
  logic [BytesPerBeat-1:0] w_wdf_head_mask;

  assign app_wdf_rdy_o   = (r_wdf_cnt != WdfCntW'(wdf_fifo_els_p));
  assign w_wdf_push      = app_wdf_wren_i & app_wdf_rdy_o;
  assign w_wdf_empty     = (r_wdf_cnt == '0);
  assign w_wdf_head_data = r_wdf_data[r_wdf_rptr];
  assign w_wdf_head_mask = r_wdf_mask[r_wdf_rptr];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wdf_wptr <= '0;
      r_wdf_rptr <= '0;
      r_wdf_cnt  <= '0;
    end else begin
      if (w_wdf_push) begin
        r_wdf_wptr <= (r_wdf_wptr == WdfPtrW'(wdf_fifo_els_p - 1)) ? '0
                                                                    : r_wdf_wptr + WdfPtrW'(1);
      end
      if (w_wdf_pop) begin
        r_wdf_rptr <= (r_wdf_rptr == WdfPtrW'(wdf_fifo_els_p - 1)) ? '0
                                                                    : r_wdf_rptr + WdfPtrW'(1);
      end
      if (w_wdf_push && !w_wdf_pop) begin
        r_wdf_cnt <= r_wdf_cnt + WdfCntW'(1);
      end else if (!w_wdf_push && w_wdf_pop) begin
        r_wdf_cnt <= r_wdf_cnt - WdfCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wdf_push) begin
      r_wdf_data[r_wdf_wptr] <= app_wdf_data_i;
      r_wdf_mask[r_wdf_wptr] <= app_wdf_mask_i;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Input-side burst framing check. The counter tracks beats as they arrive, independent of
  // which command they will eventually belong to.
  // ---------------------------------------------------------------------------------------------
  logic [BeatW-1:0] r_in_beat;
  logic             w_end_err;
  logic             w_bad_cmd;
  logic             r_error;

  assign w_end_err = w_wdf_push & (app_wdf_end_i != (r_in_beat == BeatLast));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_in_beat <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_wdf_push) begin
        r_in_beat <= (r_in_beat == BeatLast) ? '0 : r_in_beat + BeatW'(1);
      end
      if (w_end_err || w_bad_cmd) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error_o = r_error;

  // ---------------------------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------------------------
  state_e           r_state, w_state_d;
  logic [IdxW-1:0]  r_idx, w_idx_d;
  logic [BeatW-1:0] r_beat, w_beat_d;
  logic             w_rd_fire;
  logic             w_last_beat;

  assign w_last_beat = (r_beat == BeatLast);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_beat  <= w_beat_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_beat_d  = r_beat;
    w_cmd_pop = 1'b0;
    w_wdf_pop = 1'b0;
    w_rd_fire = 1'b0;
    w_bad_cmd = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_cmd_empty) begin
          w_cmd_pop = 1'b1;
          w_idx_d   = r_cmd_idx[r_cmd_rptr];
          w_beat_d  = '0;
          if (r_cmd_op[r_cmd_rptr] == CmdRd) begin
            w_state_d = StRead;
          end else if (r_cmd_op[r_cmd_rptr] == CmdWr) begin
            w_state_d = StWrite;
          end else begin
            w_bad_cmd = 1'b1;
          end
        end
      end
      StRead: begin
        w_rd_fire = 1'b1;
        w_idx_d   = r_idx + IdxW'(1);
        w_beat_d  = r_beat + BeatW'(1);
        if (w_last_beat) begin
          w_state_d = StIdle;
        end
      end
      StWrite: begin
        // Stall here for as long as write data is missing.
        if (!w_wdf_empty) begin
          w_wdf_pop = 1'b1;
          w_idx_d   = r_idx + IdxW'(1);
          w_beat_d  = r_beat + BeatW'(1);
          if (w_last_beat) begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Memory array (not reset) and registered read port
  // ---------------------------------------------------------------------------------------------
  logic [data_width_p-1:0] r_mem [mem_els_p];
  logic [data_width_p-1:0] r_rd_data;
  logic                    r_rd_valid, r_rd_end;

  always_ff @(posedge clk_i) begin
    if (w_wdf_pop && !reset_i) begin
      for (int b = 0; b < int'(BytesPerBeat); b++) begin
        if (!w_wdf_head_mask[b]) begin
          r_mem[r_idx][8*b +: 8] <= w_wdf_head_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rd_fire) begin
      r_rd_data <= r_mem[r_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_valid <= 1'b0;
      r_rd_end   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      r_rd_end   <= w_rd_fire & w_last_beat;
    end
  end

  assign app_rd_data_valid_o = r_rd_valid;
  assign app_rd_data_end_o   = r_rd_end;
  assign app_rd_data_o       = r_rd_data;

endmodule
